// File: rtl/polygon_vertex_loader.sv
// Collects one polygon's vertices into a shadow buffer and swaps it into the
// active output buffer at the first frame-start pulse after the polygon closes.
module polygon_vertex_loader #(
   parameter int MAX_NUM_VERTICES = 4,
   parameter int PIXEL_SCALE      = 1
) (
   input  logic                                  clk_in,
   input  logic                                  rst_in,
   input  logic                                  new_frame_in,
   input  logic signed [31:0]                    camera_x_in,
   input  logic signed [31:0]                    camera_y_in,
   input  logic                                  vtx_valid_in,
   output logic                                  vtx_ready_out,
   input  logic signed [31:0]                    vtx_x_in,
   input  logic signed [31:0]                    vtx_y_in,
   input  logic                                  vtx_last_in,
   output logic [MAX_NUM_VERTICES-1:0][31:0]     xs_out,
   output logic [MAX_NUM_VERTICES-1:0][31:0]     ys_out,
   output logic [$clog2(MAX_NUM_VERTICES):0]     num_points_out,
   output logic                                  poly_valid_out,
   output logic                                  overflow_out,
   output logic                                  degenerate_out
);

   localparam int CW = $clog2(MAX_NUM_VERTICES) + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NUM_VERTICES);
   localparam logic [CW-1:0] MIN_CNT = CW'(3);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_PENDING = 2'd2
   } state_t;

   state_t                               state_r;
   state_t                               state_nxt_s;
   logic                                 ready_nxt_s;
   logic                                 accept_s;
   logic                                 collect_acc_s;
   logic                                 swap_s;
   logic [CW-1:0]                        count_r;
   logic [CW-1:0]                        cnt_inc_s;
   logic [31:0]                          cam_x_r;
   logic [31:0]                          cam_y_r;
   logic [31:0]                          cam_sel_x_s;
   logic [31:0]                          cam_sel_y_s;
   logic [31:0]                          px_s;
   logic [31:0]                          py_s;
   logic [MAX_NUM_VERTICES-1:0][31:0]    shadow_x_r;
   logic [MAX_NUM_VERTICES-1:0][31:0]    shadow_y_r;

   // World-to-screen transform: wrap-around subtract then scale, low 32 bits kept.
   function automatic logic [31:0] to_screen(input logic [31:0] v, input logic [31:0] c);
      logic [31:0] d;
      d = v - c;
      return d * 32'(PIXEL_SCALE);
   endfunction

   assign accept_s  = vtx_valid_in & vtx_ready_out;
   assign cnt_inc_s = count_r + CW'(1);

   // State and registered ready
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_r       <= ST_COLLECT;
         vtx_ready_out <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         vtx_ready_out <= ready_nxt_s;
      end
   end

   // Next-state decision
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_COLLECT: begin
            if (accept_s) begin
               if (vtx_last_in) begin
                  if (cnt_inc_s >= MIN_CNT) begin
                     state_nxt_s = ST_PENDING;
                  end else begin
                     state_nxt_s = ST_COLLECT;
                  end
               end else if (cnt_inc_s == MAX_CNT) begin
                  state_nxt_s = ST_DRAIN;
               end else begin
                  state_nxt_s = ST_COLLECT;
               end
            end else begin
               state_nxt_s = ST_COLLECT;
            end
         end
         ST_DRAIN: begin
            if (accept_s && vtx_last_in) begin
               state_nxt_s = ST_PENDING;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_PENDING: begin
            if (new_frame_in) begin
               state_nxt_s = ST_COLLECT;
            end else begin
               state_nxt_s = ST_PENDING;
            end
         end
         default: state_nxt_s = ST_COLLECT;
      endcase
   end

   // Control outputs derived from the current and next state
   always_comb begin
      ready_nxt_s   = 1'b0;
      collect_acc_s = 1'b0;
      swap_s        = 1'b0;
      if (state_nxt_s != ST_PENDING) begin
         ready_nxt_s = 1'b1;
      end else begin
         ready_nxt_s = 1'b0;
      end
      if (state_r == ST_COLLECT) begin
         collect_acc_s = accept_s;
      end else begin
         collect_acc_s = 1'b0;
      end
      if (state_r == ST_PENDING) begin
         swap_s = new_frame_in;
      end else begin
         swap_s = 1'b0;
      end
   end

   // The first vertex of a polygon uses the camera it is latching.
   always_comb begin
      cam_sel_x_s = cam_x_r;
      cam_sel_y_s = cam_y_r;
      if (count_r == CW'(0)) begin
         cam_sel_x_s = camera_x_in;
         cam_sel_y_s = camera_y_in;
      end else begin
         cam_sel_x_s = cam_x_r;
         cam_sel_y_s = cam_y_r;
      end
      px_s = to_screen(vtx_x_in, cam_sel_x_s);
      py_s = to_screen(vtx_y_in, cam_sel_y_s);
   end

   // Shadow fill, camera latch, sticky flags and the shadow-to-active swap
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         count_r        <= '0;
         cam_x_r        <= 32'd0;
         cam_y_r        <= 32'd0;
         shadow_x_r     <= '0;
         shadow_y_r     <= '0;
         xs_out         <= '0;
         ys_out         <= '0;
         num_points_out <= '0;
         poly_valid_out <= 1'b0;
         overflow_out   <= 1'b0;
         degenerate_out <= 1'b0;
      end else if (swap_s) begin
         // Slots beyond the polygon may hold stale vertices; zero them.
         for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
            if (CW'(i) < count_r) begin
               xs_out[i] <= shadow_x_r[i];
               ys_out[i] <= shadow_y_r[i];
            end else begin
               xs_out[i] <= 32'd0;
               ys_out[i] <= 32'd0;
            end
         end
         num_points_out <= count_r;
         poly_valid_out <= 1'b1;
         count_r        <= '0;
      end else if (collect_acc_s) begin
         if (count_r == CW'(0)) begin
            cam_x_r <= camera_x_in;
            cam_y_r <= camera_y_in;
         end
         for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
            if (count_r == CW'(i)) begin
               shadow_x_r[i] <= px_s;
               shadow_y_r[i] <= py_s;
            end
         end
         if (vtx_last_in && (cnt_inc_s < MIN_CNT)) begin
            count_r        <= '0;
            degenerate_out <= 1'b1;
         end else begin
            count_r <= cnt_inc_s;
            if (!vtx_last_in && (cnt_inc_s == MAX_CNT)) begin
               overflow_out <= 1'b1;
            end
         end
      end
   end

endmodule
